// File: rtl/lcd_pkg.sv
// Shared state encoding and LCD bus constants for the character-LCD read engine.
// No timing of its own; imported by the reader top and its phase timer.
// No flow control here.
package lcd_pkg;

  // Read-engine sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_SETUP = 3'd2,
    ST_PULSE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Busy flag position in the status byte; bits 6:0 are the address counter
  localparam int LCD_BF_BIT = 7;

  // Register-select encodings on the LCD bus
  localparam logic RS_STATUS = 1'b0;
  localparam logic RS_DATA   = 1'b1;

  // Largest of three phase lengths, used to size the shared phase counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Bits needed to hold values 0..value
  function automatic int count_width(input int value);
    int w;
    w = 1;
    while ((1 << w) <= value) w++;
    return w;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter timing the SETUP / PULSE / HOLD bus phases.
// done is combinational from the count: a load of N-1 gives N cycles before done.
// No backpressure; a load always wins over counting.
module lcd_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load on phase entry, otherwise count down and park at zero
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read engine: status (BF + address counter) and DDRAM/CGRAM data reads, optional BF polling.
// Single phase with grant already high: rsp_valid 3+S+H+D cycles after req; each extra phase adds S+H+D+1.
// Waits in ARB for bus_gnt; req is only taken while ready=1 and is never queued.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int EN_SETUP_CYCLES = 2,
  parameter int EN_HIGH_CYCLES  = 16,
  parameter int EN_HOLD_CYCLES  = 2,
  parameter int BUSY_TIMEOUT    = 262143
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic       req_rs,
  input  logic       wait_busy,
  output logic       ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       busy_flag,
  output logic [6:0] addr_counter,
  output logic       bus_req,
  input  logic       bus_gnt,
  input  logic [7:0] _lcd_data_in,
  output logic       _lcd_data_oe,
  output logic       _lcd_rw,
  output logic       _lcd_rs,
  output logic       _lcd_en
);

  // Phase counter sized for the longest of the three bus phases
  localparam int TW = count_width(max3(EN_SETUP_CYCLES, EN_HIGH_CYCLES, EN_HOLD_CYCLES));
  localparam logic [TW-1:0] SETUP_LOAD = TW'(EN_SETUP_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(EN_HIGH_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(EN_HOLD_CYCLES - 1);

  // Poll timer saturates at all-ones of its natural width
  localparam int PW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(BUSY_TIMEOUT);
  localparam logic [PW-1:0] POLL_MAX   = '1;

  state_t          state;
  state_t          next_state;

  logic            rs_latch;    // requested kind of read, kept for the post-poll data phase
  logic            phase_rs;    // RS driven during the current bus phase
  logic            polling;     // still waiting for BF to clear
  logic [PW-1:0]   poll_timer;
  logic [7:0]      sample;      // byte captured on the last EN-high cycle

  logic            tmr_load;
  logic [TW-1:0]   tmr_value;
  logic            tmr_done;

  logic            start;
  logic            last_pulse;
  logic            poll_abort;
  logic            poll_again;
  logic            go_data;

  assign start      = (state == ST_IDLE) && req;
  assign last_pulse = (state == ST_PULSE) && tmr_done;

  // CHECK decisions, in priority order; busy_flag already holds the latest status
  assign poll_abort = polling && busy_flag && (poll_timer >= POLL_LIMIT);
  assign poll_again = polling && busy_flag && !poll_abort;
  assign go_data    = polling && !busy_flag && (rs_latch == RS_DATA);

  lcd_phase_timer #(
    .WIDTH (TW)
  ) u_phase_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; also arms the phase timer on entry to each timed phase
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    case (state)
      ST_IDLE: begin
        if (req) next_state = ST_ARB;
      end
      ST_ARB: begin
        if (bus_gnt) begin
          next_state = ST_SETUP;
          tmr_load   = 1'b1;
          tmr_value  = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          next_state = ST_PULSE;
          tmr_load   = 1'b1;
          tmr_value  = PULSE_LOAD;
        end
      end
      ST_PULSE: begin
        if (tmr_done) begin
          next_state = ST_HOLD;
          tmr_load   = 1'b1;
          tmr_value  = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (poll_again || go_data) begin
          next_state = ST_SETUP;
          tmr_load   = 1'b1;
          tmr_value  = SETUP_LOAD;
        end else begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Bus pins and handshake outputs decoded from the state
  always_comb begin
    ready     = 1'b0;
    rsp_valid = 1'b0;
    bus_req   = 1'b0;
    _lcd_rw   = 1'b0;
    _lcd_rs   = 1'b0;
    _lcd_en   = 1'b0;
    case (state)
      ST_IDLE: ready = 1'b1;
      ST_ARB:  bus_req = 1'b1;
      ST_SETUP, ST_HOLD, ST_CHECK: begin
        bus_req = 1'b1;
        _lcd_rw = 1'b1;
        _lcd_rs = phase_rs;
      end
      ST_PULSE: begin
        bus_req = 1'b1;
        _lcd_rw = 1'b1;
        _lcd_rs = phase_rs;
        _lcd_en = 1'b1;
      end
      ST_DONE: rsp_valid = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // This block only ever reads the LCD
  assign _lcd_data_oe = 1'b0;

  // Request latch and phase sequencing: status first when polling, then the requested read
  always_ff @(posedge clock) begin
    if (reset) begin
      rs_latch <= RS_STATUS;
      phase_rs <= RS_STATUS;
      polling  <= 1'b0;
    end else if (start) begin
      rs_latch <= req_rs;
      polling  <= wait_busy;
      phase_rs <= wait_busy ? RS_STATUS : req_rs;
    end else if (state == ST_CHECK) begin
      if (poll_again) begin
        phase_rs <= RS_STATUS;
      end else if (go_data) begin
        phase_rs <= RS_DATA;
        polling  <= 1'b0;
      end else begin
        polling  <= 1'b0;
      end
    end
  end

  // Poll timer: restarts with each request, counts while polling, sticks at full scale
  always_ff @(posedge clock) begin
    if (reset) begin
      poll_timer <= '0;
    end else if (start) begin
      poll_timer <= '0;
    end else if (polling && (poll_timer != POLL_MAX)) begin
      poll_timer <= poll_timer + PW'(1);
    end
  end

  // Capture the data pins at the end of EN high; status phases also refresh BF and AC
  always_ff @(posedge clock) begin
    if (reset) begin
      sample       <= 8'h00;
      busy_flag    <= 1'b0;
      addr_counter <= 7'h00;
    end else if (last_pulse) begin
      sample <= _lcd_data_in;
      if (phase_rs == RS_STATUS) begin
        busy_flag    <= _lcd_data_in[LCD_BF_BIT];
        addr_counter <= _lcd_data_in[6:0];
      end
    end
  end

  // Response registers change only on entry to DONE so they hold between responses
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_data    <= 8'h00;
      rsp_timeout <= 1'b0;
    end else if ((state == ST_CHECK) && (next_state == ST_DONE)) begin
      rsp_data    <= sample;
      rsp_timeout <= poll_abort;
    end
  end

endmodule
